fantasticfft_ifft8: RTL and testbench

FANTASTICFFT_IFFT8 -- requirements
Module: fantasticfft_ifft8

---
 rtl/fantasticfft_ifft8.sv | 141 ++++++++++++++
 tb/tb_fantasticfft_ifft8.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fantasticfft_ifft8.sv
// 8-point inverse DFT, bin-serial in / sample-serial out.
// Each accepted bin is rotated by W(k*n) and summed into all eight accumulators at once.
module fantasticfft_ifft8 #(
    parameter int INPUT_SIZE = 8,
    parameter int N          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INPUT_SIZE-1:0] in_re,
    input  logic [INPUT_SIZE-1:0] in_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INPUT_SIZE-1:0] out_re,
    output logic [INPUT_SIZE-1:0] out_im,
    output logic                  out_last
);
    localparam int W  = INPUT_SIZE;
    localparam int AW = W + 4;
    localparam int PW = AW + 9;
    localparam logic [2:0] LAST = 3'(N - 1);
    localparam logic signed [PW-1:0] K181 = PW'(181);
    localparam logic signed [AW-1:0] SMAX = AW'(2**(W-1) - 1);
    localparam logic signed [AW-1:0] SMIN = AW'(-(2**(W-1)));

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             bin_q, bin_d;
    logic [2:0]             smp_q, smp_d;
    logic signed [AW-1:0]   acc_re_q [N];
    logic signed [AW-1:0]   acc_im_q [N];
    logic signed [AW-1:0]   acc_re_d [N];
    logic signed [AW-1:0]   acc_im_d [N];
    logic signed [AW-1:0]   rot_re [N];
    logic signed [AW-1:0]   rot_im [N];
    logic signed [AW-1:0]   ax, bx;

    // P(v) = floor(v*181/256); v is carried at accumulator width so -a-b never wraps
    function automatic logic signed [AW-1:0] pmul(input logic signed [AW-1:0] v);
        logic signed [PW-1:0] pr;
        pr = PW'(v) * K181;
        return AW'(pr >>> 8);
    endfunction

    function automatic logic [2*AW-1:0] rot(input logic [2:0] m,
                                            input logic signed [AW-1:0] a,
                                            input logic signed [AW-1:0] b);
        logic signed [AW-1:0] re, im, amb, apb;
        amb = a - b;
        apb = a + b;
        case (m)
            3'd0:    begin re = a;           im = b;           end
            3'd1:    begin re = pmul(amb);   im = pmul(apb);   end
            3'd2:    begin re = -b;          im = a;           end
            3'd3:    begin re = pmul(-apb);  im = pmul(amb);   end
            3'd4:    begin re = -a;          im = -b;          end
            3'd5:    begin re = pmul(-amb);  im = pmul(-apb);  end
            3'd6:    begin re = b;           im = -a;          end
            default: begin re = pmul(apb);   im = pmul(-amb);  end
        endcase
        return {re, im};
    endfunction

    function automatic logic [W-1:0] sat(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] s;
        s = acc >>> 3;
        if (s > SMAX)      return W'(SMAX);
        else if (s < SMIN) return W'(SMIN);
        else               return W'(s);
    endfunction

    assign ax = AW'($signed(in_re));
    assign bx = AW'($signed(in_im));

    for (genvar n = 0; n < N; n++) begin : g_lane
        localparam logic [2:0] NI = 3'(n);
        logic [2:0] m;
        assign m = bin_q * NI;
        assign {rot_re[n], rot_im[n]} = rot(m, ax, bx);
    end

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        smp_d    = smp_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        case (state_q)
            ACCUM: if (in_valid) begin
                for (int n = 0; n < N; n++) begin
                    acc_re_d[n] = acc_re_q[n] + rot_re[n];
                    acc_im_d[n] = acc_im_q[n] + rot_im[n];
                end
                bin_d = bin_q + 3'd1;
                if (bin_q == LAST) begin
                    state_d = DRAIN;
                    smp_d   = 3'd0;
                end
            end
            default: if (out_ready) begin
                smp_d = smp_q + 3'd1;
                // block done: clear so the next block starts from zero
                if (smp_q == LAST) begin
                    state_d = ACCUM;
                    bin_d   = 3'd0;
                    for (int n = 0; n < N; n++) begin
                        acc_re_d[n] = '0;
                        acc_im_d[n] = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            bin_q   <= 3'd0;
            smp_q   <= 3'd0;
            for (int n = 0; n < N; n++) begin
                acc_re_q[n] <= '0;
                acc_im_q[n] <= '0;
            end
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            smp_q    <= smp_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DRAIN);
    assign out_last  = (state_q == DRAIN) && (smp_q == LAST);
    assign out_re    = (state_q == DRAIN) ? sat(acc_re_q[smp_q]) : '0;
    assign out_im    = (state_q == DRAIN) ? sat(acc_im_q[smp_q]) : '0;

endmodule

// File: tb/tb_fantasticfft_ifft8.sv
// Bench for fantasticfft_ifft8: directed vector table plus random blocks against a DFT reference.
module tb_fantasticfft_ifft8;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [W-1:0] in_re, in_im, out_re, out_im;

    always #5 clk = ~clk;

    fantasticfft_ifft8 #(.INPUT_SIZE(W), .N(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_last(out_last)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0][15:0] xr;
        logic [7:0][15:0] xi;
        logic [7:0][15:0] er;
        logic [7:0][15:0] ei;
    } vec_t;

    vec_t  tbl [3];
    string tbl_name [3] = '{"impulse", "nyquist", "imag_bin2"};

    int q_in_re[$], q_in_im[$], q_exp_re[$], q_exp_im[$];

    // Reference: direct evaluation of x[n] = 1/8 * sum X[k]*W(k*n) with the given rotation rules
    function automatic int pq(input int v);
        return (v * 181) >>> 8;
    endfunction

    function automatic void rot_ref(input int m, input int a, input int b,
                                    output int re, output int im);
        case (m)
            0: begin re = a;          im = b;          end
            1: begin re = pq(a - b);  im = pq(a + b);  end
            2: begin re = -b;         im = a;          end
            3: begin re = pq(-a - b); im = pq(a - b);  end
            4: begin re = -a;         im = -b;         end
            5: begin re = pq(b - a);  im = pq(-a - b); end
            6: begin re = b;          im = -a;         end
            default: begin re = pq(a + b); im = pq(b - a); end
        endcase
    endfunction

    function automatic int sat_ref(input int v);
        int s = v >>> 3;
        if (s > 127)  return 127;
        if (s < -128) return -128;
        return s;
    endfunction

    task automatic model_block(input int xr[8], input int xi[8]);
        for (int n = 0; n < 8; n++) begin
            int sr = 0, si = 0, r, i;
            for (int k = 0; k < 8; k++) begin
                rot_ref((k * n) % 8, xr[k], xi[k], r, i);
                sr += r;
                si += i;
            end
            q_exp_re.push_back(sat_ref(sr));
            q_exp_im.push_back(sat_ref(si));
        end
        for (int k = 0; k < 8; k++) begin
            q_in_re.push_back(xr[k]);
            q_in_im.push_back(xi[k]);
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int k = 0; k < 8; k++) begin
            q_in_re.push_back(int'($signed(v.xr[k])));
            q_in_im.push_back(int'($signed(v.xi[k])));
            q_exp_re.push_back(int'($signed(v.er[k])));
            q_exp_im.push_back(int'($signed(v.ei[k])));
        end
    endtask

    // Streams every queued bin with in_valid held high and collects all samples.
    // Output at global index stall_at is backpressured for stall_len cycles.
    task automatic stream(input string tag, input int stall_at, input int stall_len);
        int total = q_in_re.size();
        int ii = 0, oi = 0, cyc = 0, stall_cnt = 0;
        int last_out_cyc = -100, acc8_cyc = -100;
        while (oi < total && cyc < 40 * total + 50) begin
            @(negedge clk);
            cyc++;
            chk({tag, " in_ready==!out_valid"}, int'(in_ready), int'(!out_valid));
            if (acc8_cyc == cyc - 1)
                chk({tag, " latency out_valid"}, int'(out_valid), 1);
            if (out_valid) begin
                chk($sformatf("%s re[%0d]", tag, oi), int'($signed(out_re)), q_exp_re[oi]);
                chk($sformatf("%s im[%0d]", tag, oi), int'($signed(out_im)), q_exp_im[oi]);
                chk($sformatf("%s last[%0d]", tag, oi), int'(out_last), int'(oi % 8 == 7));
                out_ready = !(oi == stall_at && stall_cnt < stall_len);
                if (!out_ready) stall_cnt++;
                else begin
                    if (oi % 8 == 7) last_out_cyc = cyc;
                    oi++;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (ii < total) begin
                in_valid = 1'b1;
                in_re    = W'(q_in_re[ii]);
                in_im    = W'(q_in_im[ii]);
                if (in_ready) begin
                    if (ii > 0 && ii % 8 == 0)
                        chk({tag, " back-to-back gap"}, cyc - last_out_cyc, 1);
                    if (ii % 8 == 7) acc8_cyc = cyc;
                    ii++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        chk({tag, " samples delivered"}, oi, total);
        if (stall_len > 0) chk({tag, " stall cycles"}, stall_cnt, stall_len);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        q_in_re.delete();  q_in_im.delete();
        q_exp_re.delete(); q_exp_im.delete();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " in_ready"},  int'(in_ready), 1);
        chk({tag, " out_valid"}, int'(out_valid), 0);
        chk({tag, " out_last"},  int'(out_last), 0);
        chk({tag, " out_re"},    int'(out_re), 0);
        chk({tag, " out_im"},    int'(out_im), 0);
    endtask

    initial begin
        int xr[8], xi[8];

        for (int i = 0; i < 3; i++) tbl[i] = '0;
        tbl[0].xr[0] = 16'(64);
        tbl[1].xr[4] = 16'(64);
        tbl[2].xi[2] = 16'(64);
        for (int k = 0; k < 8; k++) begin
            tbl[0].er[k] = 16'(8);
            tbl[1].er[k] = (k % 2 == 0) ? 16'(8) : 16'(-8);
            case (k % 4)
                0: tbl[2].ei[k] = 16'(8);
                1: tbl[2].er[k] = 16'(-8);
                2: tbl[2].ei[k] = 16'(-8);
                default: tbl[2].er[k] = 16'(8);
            endcase
        end

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_re = '0; in_im = '0;
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            load_vec(tbl[i]);
            stream(tbl_name[i], -1, 0);
        end

        load_vec(tbl[1]);
        stream("backpressure", 2, 3);

        // partial block then reset with a handshake pending
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_re    = W'($urandom_range(0, 255));
            in_im    = W'($urandom_range(0, 255));
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk_reset_state("mid-block reset");
        load_vec(tbl[0]);
        stream("after reset impulse", -1, 0);

        load_vec(tbl[0]);
        load_vec(tbl[1]);
        stream("back-to-back", -1, 0);

        // coherent block drives n=1 into saturation
        xr = '{127, 127, 0, -127, -127, -127, 0, 127};
        xi = '{0, -127, -127, -127, 0, 127, 127, 127};
        model_block(xr, xi);
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 8; k++) begin
                xr[k] = int'($urandom_range(0, 255)) - 128;
                xi[k] = int'($urandom_range(0, 255)) - 128;
            end
            model_block(xr, xi);
        end
        stream("random", 13, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
